// File: rtl/hex_bcd_display.sv
// hex_bcd_display
//   Display back end for the CPU's 32-bit display register. It drives eight
//   active-low seven-segment digits. In hex mode each nibble of the captured
//   value is shown on one digit. In decimal mode the value is converted to BCD
//   by a sequential double-dabble engine (one bit per clock), and values above
//   99_999_999 are flagged and shown as dashes. A new conversion starts
//   automatically whenever value or mode differs from the last captured pair.
//
//   Optional build macro: HEXDISP_LZB_EN
//     Enables leading-zero blanking of every digit above the most significant
//     nonzero digit. Digit 0 is never blanked, and the overflow dashes are not
//     affected.
//
// Ports
//   clk       in   1         clock
//   rst_n     in   1         synchronous active-low reset
//   value     in   IN_W      binary value from the CPU display register
//   mode      in   1         0 = hex, 1 = unsigned decimal
//   seg       out  7*DIGITS  digit i on seg[7i+6:7i], {g,f,e,d,c,b,a}, active-low
//   busy      out  1         conversion in flight (state != IDLE)
//   overflow  out  1         decimal mode and value > 99_999_999
module hex_bcd_display #(
  parameter int DIGITS = 8,
  parameter int IN_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_W-1:0]       value,
  input  logic                  mode,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  busy,
  output logic                  overflow
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                overflow_q, overflow_d;
  logic [7*DIGITS-1:0] seg_q, seg_d;
  logic [IN_W-1:0]     last_value_q, last_value_d;
  logic                last_mode_q, last_mode_d;
  logic                dirty_q, dirty_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [IN_W-1:0]     bin_q, bin_d;
  logic [39:0]         bcd_q, bcd_d;

  // Display image computed from the captured inputs and the finished BCD.
  logic [7*DIGITS-1:0] disp_seg;
  logic                disp_ovf;
  logic [39:0]         bcd_adj;

  // Hex glyph for one nibble, {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift,
  // all digits evaluated in parallel on the pre-shift value.
  function automatic logic [39:0] dabble_adj(input logic [39:0] b);
    logic [39:0] r;
    r = b;
    for (int i = 0; i < 10; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign bcd_adj = dabble_adj(bcd_q);

  always_comb begin
    logic [3:0] nib [DIGITS];
    logic       seen;
    disp_seg = '1;
    disp_ovf = last_mode_q && (bcd_q[39:32] != 8'd0);
    seen     = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      nib[i] = last_mode_q ? bcd_q[4*i +: 4] : last_value_q[4*i +: 4];
    end
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (nib[i] != 4'd0 || i == 0) seen = 1'b1;
`ifdef HEXDISP_LZB_EN
      disp_seg[7*i +: 7] = seen ? glyph(nib[i]) : SEG_BLANK;
`else
      disp_seg[7*i +: 7] = glyph(nib[i]);
`endif
      if (disp_ovf) disp_seg[7*i +: 7] = SEG_DASH;
    end
  end

  always_comb begin
    state_d      = state_q;
    overflow_d   = overflow_q;
    seg_d        = seg_q;
    last_value_d = last_value_q;
    last_mode_d  = last_mode_q;
    dirty_d      = dirty_q;
    cnt_d        = cnt_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    case (state_q)
      IDLE: begin
        if (dirty_q || (value != last_value_q) || (mode != last_mode_q)) begin
          bin_d        = value;
          bcd_d        = '0;
          last_value_d = value;
          last_mode_d  = mode;
          dirty_d      = 1'b0;
          cnt_d        = '0;
          state_d      = mode ? CONV : DONE;
        end
      end
      CONV: begin
        bcd_d = {bcd_adj[38:0], bin_q[IN_W-1]};
        bin_d = {bin_q[IN_W-2:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = DONE;
      end
      DONE: begin
        seg_d      = disp_seg;
        overflow_d = disp_ovf;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      seg_q        <= '1;
      last_value_q <= '0;
      last_mode_q  <= 1'b0;
      dirty_q      <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
      seg_q        <= seg_d;
      last_value_q <= last_value_d;
      last_mode_q  <= last_mode_d;
      dirty_q      <= dirty_d;
      cnt_q        <= cnt_d;
    end
  end

  // Datapath shift registers: always reloaded at capture, so no reset needed.
  always_ff @(posedge clk) begin
    bin_q <= bin_d;
    bcd_q <= bcd_d;
  end

  assign seg      = seg_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_hex_bcd_display.sv
// Directed testbench for hex_bcd_display.
module tb_hex_bcd_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] value;
  logic        mode;
  logic [55:0] seg;
  logic        busy;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G6 = 7'b0000010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] G9 = 7'b0010000;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GB = 7'b0000011;
  localparam logic [6:0] GD = 7'b0100001;
  localparam logic [6:0] GE = 7'b0000110;
  localparam logic [6:0] GF = 7'b0001110;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DS = 7'b0111111;
`ifdef HEXDISP_LZB_EN
  localparam logic [6:0] LZ = BL;
`else
  localparam logic [6:0] LZ = G0;
`endif

  hex_bcd_display dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value    (value),
    .mode     (mode),
    .seg      (seg),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [55:0] obs, input logic [55:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    value = 32'd0;
    mode  = 1'b1;
    step(2);
    check("rst_busy", 56'(busy), 56'd0);
    check("rst_ovf",  56'(overflow), 56'd0);
    check("rst_seg",  seg, {8{BL}});

    // first post-reset edge captures value 0 in decimal mode
    rst_n = 1'b1;
    step(1);
    check("zero_busy_E", 56'(busy), 56'd1);
    step(33);
    check("zero_busy", 56'(busy), 56'd0);
    check("zero_ovf",  56'(overflow), 56'd0);
    check("zero_seg",  seg, {LZ, LZ, LZ, LZ, LZ, LZ, LZ, G0});

    value = 32'd12_345_678;
    step(34);
    check("dec8_d0",  56'(seg[6:0]), 56'(G8));
    check("dec8_d7",  56'(seg[55:49]), 56'(G1));
    check("dec8_seg", seg, {G1, G2, G3, G4, G5, G6, G7, G8});
    check("dec8_ovf", 56'(overflow), 56'd0);

    value = 32'hDEAD_BEEF;
    mode  = 1'b0;
    step(1);
    check("hex_busy_E",  56'(busy), 56'd1);
    step(1);
    check("hex_busy_E1", 56'(busy), 56'd0);
    check("hex_seg",     seg, {GD, GE, GA, GD, GB, GE, GE, GF});
    check("hex_ovf",     56'(overflow), 56'd0);

    value = 32'h0000_00A0;
    step(2);
    check("hex_small", seg, {LZ, LZ, LZ, LZ, LZ, LZ, GA, G0});

    value = 32'd100_000_000;
    mode  = 1'b1;
    step(34);
    check("ovf_flag", 56'(overflow), 56'd1);
    check("ovf_seg",  seg, {8{DS}});

    value = 32'd99_999_999;
    step(34);
    check("max_flag", 56'(overflow), 56'd0);
    check("max_seg",  seg, {8{G9}});

    value = 32'hFFFF_FFFF;
    step(34);
    check("full_flag", 56'(overflow), 56'd1);
    check("full_seg",  seg, {8{DS}});

    // change while busy: old value finishes, new value recaptured right after
    value = 32'd5;
    step(1);
    step(10);
    value = 32'd7;
    step(23);
    check("skip_busy", 56'(busy), 56'd0);
    check("skip_seg5", seg, {LZ, LZ, LZ, LZ, LZ, LZ, LZ, G5});
    step(1);
    check("recap_busy", 56'(busy), 56'd1);
    step(33);
    check("recap_seg7", seg, {LZ, LZ, LZ, LZ, LZ, LZ, LZ, G7});

    // reset in the middle of a conversion
    value = 32'd42;
    step(1);
    step(14);
    rst_n = 1'b0;
    step(1);
    check("midrst_seg",  seg, {8{BL}});
    check("midrst_busy", 56'(busy), 56'd0);
    check("midrst_ovf",  56'(overflow), 56'd0);
    rst_n = 1'b1;
    step(34);
    check("postrst_busy", 56'(busy), 56'd0);
    check("postrst_seg",  seg, {LZ, LZ, LZ, LZ, LZ, LZ, G4, G2});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_bcd_display.md
# hex_bcd_display

Display back end that sits directly downstream of the CPU's 32-bit `display` register and drives eight active-low seven-segment digits. In decimal mode it converts the binary value to BCD with a sequential double-dabble engine, one bit per cycle. In hex mode it shows the eight nibbles directly. It re-converts automatically whenever the input value or mode changes and flags values that do not fit in eight decimal digits.

## Interface
- `DIGITS`, 8: number of displayed digits. Fixed at 8; other values are not supported.
- `IN_W`, 32: input width. Fixed at 32.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `value`  in  32  binary value from the CPU display register
- `mode`  in  1  0 = hex (one nibble per digit), 1 = unsigned decimal
- `seg`  out  56  digit i on `seg[7i+6:7i]`, bit order {g,f,e,d,c,b,a}, active-low; digit 0 is the least significant
- `busy`  out  1  high while a conversion is in flight
- `overflow`  out  1  decimal mode and `value` > 99_999_999

## Operation
- FSM states: IDLE, CONV, DONE.
- Internal registers:
  - `last_value[31:0]`, `last_mode`: last captured inputs.
  - `dirty`: set by reset.
  - `bin[31:0]`: binary shift register.
  - `bcd[39:0]`: 10 BCD digits.
  - `cnt[4:0]`: iteration counter.
- IDLE: an edge captures when `dirty`, or `value` != `last_value`, or `mode` != `last_mode`. A capture does the following:
  - `bin` <= `value`, `bcd` <= 0, `last_value`/`last_mode` <= inputs, `dirty` <= 0, `cnt` <= 0.
  - Next state is CONV if `mode`=1, otherwise DONE.
- CONV: each edge performs one double-dabble iteration:
  - Every BCD digit ≥ 5 gets +3, then {`bcd`,`bin`} shifts left by 1.
  - The +3 step uses the pre-shift digits, all digits in parallel, in the same cycle.
  - `cnt` increments. The edge at which `cnt`=31 performs the 32nd iteration and moves to DONE.
- DONE: one edge registers `seg` and `overflow`, then returns to IDLE.
  - Hex mode: digit i = glyph of `last_value[4i+3:4i]`.
  - Decimal mode, `bcd[39:32]` != 0: `overflow` <= 1 and every digit <= '-' (7'b0111111).
  - Decimal mode otherwise: `overflow` <= 0 and digit i = glyph of `bcd[4i+3:4i]`.
  - Hex mode always sets `overflow` <= 0.
- Glyphs use standard hex encoding: '0'=1000000, '1'=1111001, '8'=0000000, 'd'=0100001, 'E'=0000110, 'F'=0001110, 'A'=0001000, 'b'=0000011. Blank = 1111111.
- `busy` = (state != IDLE), registered with the state.
- Input changes while `busy` are ignored. Because they still differ from `last_value`, they trigger a new capture on the first IDLE edge. Intermediate values may be skipped; the final value is always displayed.
- `seg`/`overflow` hold their values between DONE updates, so there are no partial results on the outputs.

## Timing
- Reset, at an edge with `rst_n`=0:
  - state = IDLE, `dirty` = 1, `busy` = 0, `overflow` = 0, `seg` = all ones (blank).
  - `last_value` = 0, `last_mode` = 0, `cnt` = 0.
- Reset mid-conversion aborts the conversion with the same values. The first post-reset edge captures.
- Latency, with capture at edge E:
  - Decimal: CONV iterations at E+1…E+32, `seg` valid after E+33. `busy` is high from after E through E+33.
  - Hex: `seg` valid after E+1.
- A back-to-back change detected in IDLE after E+33 is captured at E+34. No bubble beyond the single IDLE edge.

## Configuration
- `HEXDISP_LZB_EN` defined: leading-zero blanking. At DONE, every digit above the most significant nonzero digit is blanked. Digit 0 is never blanked. Applies to both modes; not applied to the overflow dashes.
- Not defined: all eight digits are always shown, including leading zeros.

## Test plan
- Reset 2 cycles, `value`=0, `mode`=1 → capture on the first edge. After E+33: `busy`=0, `overflow`=0, digit 0 = '0'. Digits 7..1 = '0' without the macro, blank with it.
- `value`=12_345_678, `mode`=1 → after 34 edges: `seg[6:0]`=0000000 ('8'), `seg[55:49]`=1111001 ('1'), `overflow`=0.
- `value`=32'hDEADBEEF, `mode`=0 → after 2 edges, digits 7..0 read d,E,A,d,b,E,E,F; `busy` is high for exactly 1 cycle.
- `value`=100_000_000, `mode`=1 → `overflow`=1 and all 8 digits 0111111. Then `value`=99_999_999 → `overflow`=0 and all digits '9' (0010000).
- `value`=5 captured at E; `value`=7 applied at E+10 → `seg` shows 5 after E+33. Recapture at E+34 shows 7 after E+67.
- `rst_n` low at E+15 of a decimal conversion → next cycle `seg` is blank and `busy`=0. After release, the current `value` is converted and displayed 34 edges later.
